// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the two-master memory bus arbiter
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_IFU_RD = 2'b01,
    ST_LSU_RD = 2'b10,
    ST_LSU_WR = 2'b11
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Encoding of the last_grant bit used by the round-robin build.
  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/mem_bus_arb_grant.sv
// rtl/mem_bus_arb_grant.sv - combinational grant selector; MEM_BUS_ARB_RR_EN selects round-robin
// over the default fixed LSU-over-IFU priority.
module mem_bus_arb_grant
  import mem_bus_arbiter_pkg::*;
(
  input  logic       i_ifu_req,
  input  logic       i_lsu_rd_req,
  input  logic       i_lsu_wr_req,
`ifdef MEM_BUS_ARB_RR_EN
  input  logic       i_last_grant,
`endif
  output arb_state_e o_next_state
);

  logic       w_lsu_req;
  logic       w_lsu_wins;
  arb_state_e w_lsu_state;

  assign w_lsu_req   = i_lsu_rd_req | i_lsu_wr_req;
  // An LSU read always goes ahead of a concurrent LSU write.
  assign w_lsu_state = i_lsu_rd_req ? ST_LSU_RD : ST_LSU_WR;

`ifdef MEM_BUS_ARB_RR_EN
  assign w_lsu_wins = w_lsu_req & (~i_ifu_req | (i_last_grant == GRANT_IFU));
`else
  assign w_lsu_wins = w_lsu_req;
`endif

  always_comb begin
    o_next_state = ST_IDLE;
    if (w_lsu_wins) begin
      o_next_state = w_lsu_state;
    end else if (i_ifu_req) begin
      o_next_state = ST_IFU_RD;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - whole-transaction arbiter sharing one AXI slave port between IFU and LSU;
// MEM_BUS_ARB_RR_EN enables round-robin grant.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic [ADDR_W-1:0]   i_ifu_araddr,
  input  logic [7:0]          i_ifu_arlen,
  input  logic [1:0]          i_ifu_arburst,
  input  logic                i_ifu_arvalid,
  output logic                o_ifu_arready,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic [1:0]          o_ifu_rresp,
  output logic                o_ifu_rlast,
  output logic                o_ifu_rvalid,
  input  logic                i_ifu_rready,

  input  logic [ADDR_W-1:0]   i_lsu_araddr,
  input  logic [7:0]          i_lsu_arlen,
  input  logic [1:0]          i_lsu_arburst,
  input  logic                i_lsu_arvalid,
  output logic                o_lsu_arready,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic [1:0]          o_lsu_rresp,
  output logic                o_lsu_rlast,
  output logic                o_lsu_rvalid,
  input  logic                i_lsu_rready,
  input  logic [ADDR_W-1:0]   i_lsu_awaddr,
  input  logic [7:0]          i_lsu_awlen,
  input  logic                i_lsu_awvalid,
  output logic                o_lsu_awready,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  input  logic                i_lsu_wlast,
  input  logic                i_lsu_wvalid,
  output logic                o_lsu_wready,
  output logic [1:0]          o_lsu_bresp,
  output logic                o_lsu_bvalid,
  input  logic                i_lsu_bready,

  output logic [ADDR_W-1:0]   o_out_araddr,
  output logic [7:0]          o_out_arlen,
  output logic [1:0]          o_out_arburst,
  output logic                o_out_arvalid,
  input  logic                i_out_arready,
  input  logic [DATA_W-1:0]   i_out_rdata,
  input  logic [1:0]          i_out_rresp,
  input  logic                i_out_rlast,
  input  logic                i_out_rvalid,
  output logic                o_out_rready,
  output logic [ADDR_W-1:0]   o_out_awaddr,
  output logic [7:0]          o_out_awlen,
  output logic                o_out_awvalid,
  input  logic                i_out_awready,
  output logic [DATA_W-1:0]   o_out_wdata,
  output logic [DATA_W/8-1:0] o_out_wstrb,
  output logic                o_out_wlast,
  output logic                o_out_wvalid,
  input  logic                i_out_wready,
  input  logic [1:0]          i_out_bresp,
  input  logic                i_out_bvalid,
  output logic                o_out_bready
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic       r_ar_done;
  logic       r_aw_done;
  logic       w_ar_hs;
  logic       w_aw_hs;
  logic       w_r_end;
  logic       w_b_end;

`ifdef MEM_BUS_ARB_RR_EN
  logic       r_last_grant;
`endif

  mem_bus_arb_grant u_grant (
    .i_ifu_req    (i_ifu_arvalid),
    .i_lsu_rd_req (i_lsu_arvalid),
    .i_lsu_wr_req (i_lsu_awvalid),
`ifdef MEM_BUS_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_next_state (w_next_state)
  );

  assign w_ar_hs = o_out_arvalid & i_out_arready;
  assign w_aw_hs = o_out_awvalid & i_out_awready;
  // o_out_rready / o_out_bready are only nonzero in the matching granted state.
  assign w_r_end = i_out_rvalid & o_out_rready & i_out_rlast;
  assign w_b_end = i_out_bvalid & o_out_bready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
      r_last_grant <= GRANT_IFU;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= w_next_state;
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
          if (w_next_state != ST_IDLE) begin
            r_last_grant <= (w_next_state == ST_IFU_RD) ? GRANT_IFU : GRANT_LSU;
          end
`endif
        end
        ST_IFU_RD, ST_LSU_RD: begin
          if (w_ar_hs) begin
            r_ar_done <= 1'b1;
          end
          if (w_r_end) begin
            r_state <= ST_IDLE;
          end
        end
        ST_LSU_WR: begin
          if (w_aw_hs) begin
            r_aw_done <= 1'b1;
          end
          if (w_b_end) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Granted master is wired straight through; everything else, and all of IDLE, reads as zero.
  always_comb begin
    o_ifu_arready = 1'b0;
    o_ifu_rdata   = '0;
    o_ifu_rresp   = '0;
    o_ifu_rlast   = 1'b0;
    o_ifu_rvalid  = 1'b0;
    o_lsu_arready = 1'b0;
    o_lsu_rdata   = '0;
    o_lsu_rresp   = '0;
    o_lsu_rlast   = 1'b0;
    o_lsu_rvalid  = 1'b0;
    o_lsu_awready = 1'b0;
    o_lsu_wready  = 1'b0;
    o_lsu_bresp   = '0;
    o_lsu_bvalid  = 1'b0;
    o_out_araddr  = '0;
    o_out_arlen   = '0;
    o_out_arburst = '0;
    o_out_arvalid = 1'b0;
    o_out_rready  = 1'b0;
    o_out_awaddr  = '0;
    o_out_awlen   = '0;
    o_out_awvalid = 1'b0;
    o_out_wdata   = '0;
    o_out_wstrb   = '0;
    o_out_wlast   = 1'b0;
    o_out_wvalid  = 1'b0;
    o_out_bready  = 1'b0;
    case (r_state)
      ST_IFU_RD: begin
        o_out_araddr  = i_ifu_araddr;
        o_out_arlen   = i_ifu_arlen;
        o_out_arburst = i_ifu_arburst;
        o_out_arvalid = i_ifu_arvalid & ~r_ar_done;
        o_ifu_arready = i_out_arready & ~r_ar_done;
        o_ifu_rdata   = i_out_rdata;
        o_ifu_rresp   = i_out_rresp;
        o_ifu_rlast   = i_out_rlast;
        o_ifu_rvalid  = i_out_rvalid;
        o_out_rready  = i_ifu_rready;
      end
      ST_LSU_RD: begin
        o_out_araddr  = i_lsu_araddr;
        o_out_arlen   = i_lsu_arlen;
        o_out_arburst = i_lsu_arburst;
        o_out_arvalid = i_lsu_arvalid & ~r_ar_done;
        o_lsu_arready = i_out_arready & ~r_ar_done;
        o_lsu_rdata   = i_out_rdata;
        o_lsu_rresp   = i_out_rresp;
        o_lsu_rlast   = i_out_rlast;
        o_lsu_rvalid  = i_out_rvalid;
        o_out_rready  = i_lsu_rready;
      end
      ST_LSU_WR: begin
        o_out_awaddr  = i_lsu_awaddr;
        o_out_awlen   = i_lsu_awlen;
        o_out_awvalid = i_lsu_awvalid & ~r_aw_done;
        o_lsu_awready = i_out_awready & ~r_aw_done;
        o_out_wdata   = i_lsu_wdata;
        o_out_wstrb   = i_lsu_wstrb;
        o_out_wlast   = i_lsu_wlast;
        o_out_wvalid  = i_lsu_wvalid;
        o_lsu_wready  = i_out_wready;
        o_lsu_bresp   = i_out_bresp;
        o_lsu_bvalid  = i_out_bvalid;
        o_out_bready  = i_lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter; honours MEM_BUS_ARB_RR_EN
// for the expected grant order.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, out_araddr, out_awaddr;
  logic [7:0]  ifu_arlen, lsu_arlen, lsu_awlen, out_arlen, out_awlen;
  logic [1:0]  ifu_arburst, lsu_arburst, out_arburst;
  logic        ifu_arvalid, ifu_arready, lsu_arvalid, lsu_arready, out_arvalid, out_arready;
  logic [31:0] ifu_rdata, lsu_rdata, out_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, out_rresp;
  logic        ifu_rlast, ifu_rvalid, ifu_rready, lsu_rlast, lsu_rvalid, lsu_rready;
  logic        out_rlast, out_rvalid, out_rready;
  logic        lsu_awvalid, lsu_awready, out_awvalid, out_awready;
  logic [31:0] lsu_wdata, out_wdata;
  logic [3:0]  lsu_wstrb, out_wstrb;
  logic        lsu_wlast, lsu_wvalid, lsu_wready, out_wlast, out_wvalid, out_wready;
  logic [1:0]  lsu_bresp, out_bresp;
  logic        lsu_bvalid, lsu_bready, out_bvalid, out_bready;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ifu_araddr(ifu_araddr), .i_ifu_arlen(ifu_arlen), .i_ifu_arburst(ifu_arburst),
    .i_ifu_arvalid(ifu_arvalid), .o_ifu_arready(ifu_arready),
    .o_ifu_rdata(ifu_rdata), .o_ifu_rresp(ifu_rresp), .o_ifu_rlast(ifu_rlast),
    .o_ifu_rvalid(ifu_rvalid), .i_ifu_rready(ifu_rready),
    .i_lsu_araddr(lsu_araddr), .i_lsu_arlen(lsu_arlen), .i_lsu_arburst(lsu_arburst),
    .i_lsu_arvalid(lsu_arvalid), .o_lsu_arready(lsu_arready),
    .o_lsu_rdata(lsu_rdata), .o_lsu_rresp(lsu_rresp), .o_lsu_rlast(lsu_rlast),
    .o_lsu_rvalid(lsu_rvalid), .i_lsu_rready(lsu_rready),
    .i_lsu_awaddr(lsu_awaddr), .i_lsu_awlen(lsu_awlen), .i_lsu_awvalid(lsu_awvalid),
    .o_lsu_awready(lsu_awready),
    .i_lsu_wdata(lsu_wdata), .i_lsu_wstrb(lsu_wstrb), .i_lsu_wlast(lsu_wlast),
    .i_lsu_wvalid(lsu_wvalid), .o_lsu_wready(lsu_wready),
    .o_lsu_bresp(lsu_bresp), .o_lsu_bvalid(lsu_bvalid), .i_lsu_bready(lsu_bready),
    .o_out_araddr(out_araddr), .o_out_arlen(out_arlen), .o_out_arburst(out_arburst),
    .o_out_arvalid(out_arvalid), .i_out_arready(out_arready),
    .i_out_rdata(out_rdata), .i_out_rresp(out_rresp), .i_out_rlast(out_rlast),
    .i_out_rvalid(out_rvalid), .o_out_rready(out_rready),
    .o_out_awaddr(out_awaddr), .o_out_awlen(out_awlen), .o_out_awvalid(out_awvalid),
    .i_out_awready(out_awready),
    .o_out_wdata(out_wdata), .o_out_wstrb(out_wstrb), .o_out_wlast(out_wlast),
    .o_out_wvalid(out_wvalid), .i_out_wready(out_wready),
    .i_out_bresp(out_bresp), .i_out_bvalid(out_bvalid), .o_out_bready(out_bready)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  bit          mdl_last_lsu = 1'b0;
  int          glog[$];
  logic [31:0] wr_first_data = 32'h0;
  bit          wr_use_first = 1'b0;
  logic [1:0]  b_resp_val = 2'b00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic slave_quiet;
    out_arready = 0; out_rvalid = 0; out_rdata = 0; out_rresp = 0; out_rlast = 0;
    out_awready = 0; out_wready = 0; out_bvalid = 0; out_bresp = 0;
  endtask

  task automatic master_quiet;
    ifu_rready = 0; lsu_rready = 0; lsu_wvalid = 0; lsu_wlast = 0; lsu_wdata = 0;
    lsu_wstrb = 0; lsu_bready = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctl"}, {ifu_arready, ifu_rvalid, ifu_rlast, lsu_arready, lsu_rvalid, lsu_rlast,
         lsu_awready, lsu_wready, lsu_bvalid, out_arvalid, out_rready, out_awvalid, out_wvalid,
         out_wlast, out_bready}, 64'h0);
    chk({tag, "_addr"}, {out_araddr, out_awaddr}, 64'h0);
    chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 64'h0);
    chk({tag, "_misc"}, {out_wdata, out_arlen, out_awlen, out_wstrb, out_arburst, ifu_rresp,
         lsu_rresp, lsu_bresp}, 64'h0);
  endtask

  // Reference grant rule: 0 none, 1 IFU read, 2 LSU read, 3 LSU write.
  function automatic int pick(input logic ifu, input logic lrd, input logic lwr);
    bit lsu;
    bit ifu_turn;
    lsu = lrd || lwr;
    ifu_turn = 1'b0;
`ifdef MEM_BUS_ARB_RR_EN
    ifu_turn = mdl_last_lsu;
`endif
    if (!ifu && !lsu) return 0;
    if (ifu && (!lsu || ifu_turn)) return 1;
    return lrd ? 2 : 3;
  endfunction

  task automatic do_reset;
    rst = 1; ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0;
    slave_quiet(); master_quiet();
    step(); step();
    check_idle("reset");
    rst = 0;
    mdl_last_lsu = 1'b0;
  endtask

  task automatic serve_rd(input bit is_ifu, input int ar_stall, input int rst_beat, input bit reissue);
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          hs_cnt = 0;
    int          beat = 0;
    int          cyc = 0;
    bit          hs;
    bit          rr;
    addr  = is_ifu ? ifu_araddr : lsu_araddr;
    len   = is_ifu ? ifu_arlen : lsu_arlen;
    burst = is_ifu ? ifu_arburst : lsu_arburst;
    slave_quiet(); master_quiet();
    for (int s = 0; s <= ar_stall; s++) begin
      out_arready = (s == ar_stall);
      #1;
      chk("ar_valid", out_arvalid, 1'b1);
      chk("ar_addr", out_araddr, addr);
      chk("ar_len_burst", {out_arlen, out_arburst}, {len, burst});
      chk("ar_ready_own", is_ifu ? ifu_arready : lsu_arready, out_arready);
      chk("ar_other_blocked", {is_ifu ? lsu_arready : ifu_arready, lsu_awready, out_awvalid}, 0);
      if (out_arvalid && out_arready) hs_cnt++;
      step();
    end
    out_arready = 0;
    if (reissue) begin
      if (is_ifu) ifu_araddr = ifu_araddr + 32'h40;
      else lsu_araddr = lsu_araddr + 32'h40;
    end else begin
      if (is_ifu) ifu_arvalid = 0;
      else lsu_arvalid = 0;
    end
    while (beat <= int'(len) && cyc < 64) begin
      out_rvalid  = ($urandom_range(0, 3) != 0);
      out_rdata   = $urandom;
      out_rresp   = 2'($urandom);
      out_rlast   = (beat == int'(len));
      out_arready = 1'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      if (is_ifu) ifu_rready = rr; else lsu_rready = rr;
      #1;
      if (is_ifu) begin
        chk("r_ctl_ifu", {ifu_rvalid, ifu_rlast, ifu_rresp, lsu_rvalid}, {out_rvalid, out_rlast, out_rresp, 1'b0});
        chk("r_data_ifu", ifu_rdata, out_rdata);
      end else begin
        chk("r_ctl_lsu", {lsu_rvalid, lsu_rlast, lsu_rresp, ifu_rvalid}, {out_rvalid, out_rlast, out_rresp, 1'b0});
        chk("r_data_lsu", lsu_rdata, out_rdata);
      end
      chk("r_ready", out_rready, rr);
      chk("ar_guard", {out_arvalid, ifu_arready, lsu_arready}, 0);
      if (out_arvalid && out_arready) hs_cnt++;
      hs = out_rvalid && rr;
      step();
      cyc++;
      if (hs) beat++;
      if (hs && beat == rst_beat) begin
        rst = 1; out_rvalid = 1; ifu_rready = 1; lsu_rready = 1;
        if (is_ifu) ifu_arvalid = 0; else lsu_arvalid = 0;
        step();
        rst = 0;
        mdl_last_lsu = 1'b0;
        #1;
        check_idle("rst_mid_burst");
        slave_quiet(); master_quiet();
        return;
      end
    end
    chk("r_beats", beat, int'(len) + 1);
    chk("ar_hs_count", hs_cnt, 1);
    slave_quiet(); master_quiet();
  endtask

  task automatic serve_wr(input int aw_stall, input int b_delay);
    logic [31:0] addr;
    logic [7:0]  len;
    int          beat = 0;
    int          cyc = 0;
    bit          hs;
    addr = lsu_awaddr;
    len  = lsu_awlen;
    slave_quiet(); master_quiet();
    for (int s = 0; s <= aw_stall; s++) begin
      out_awready = (s == aw_stall);
      #1;
      chk("aw_valid", out_awvalid, 1'b1);
      chk("aw_addr_len", {out_awaddr, out_awlen}, {addr, len});
      chk("aw_ready_own", lsu_awready, out_awready);
      chk("aw_other_blocked", {out_arvalid, ifu_arready, lsu_arready}, 0);
      step();
    end
    out_awready = 0;
    lsu_awvalid = 0;
    lsu_wdata = wr_use_first ? wr_first_data : $urandom;
    while (beat <= int'(len) && cyc < 64) begin
      lsu_wvalid = 1;
      lsu_wstrb  = wr_use_first ? 4'hF : 4'($urandom);
      lsu_wlast  = (beat == int'(len));
      out_wready = ($urandom_range(0, 2) != 0);
      #1;
      chk("w_fwd", {out_wvalid, out_wlast, out_wstrb, out_wdata}, {1'b1, lsu_wlast, lsu_wstrb, lsu_wdata});
      chk("w_ready", {lsu_wready, out_awvalid, ifu_arready}, {out_wready, 2'b00});
      hs = out_wready;
      step();
      cyc++;
      if (hs) begin
        beat++;
        lsu_wdata = $urandom;
      end
    end
    chk("w_beats", beat, int'(len) + 1);
    lsu_wvalid = 0; lsu_wlast = 0; out_wready = 0;
    lsu_bready = 1;
    for (int d = 0; d <= b_delay; d++) begin
      out_bvalid = (d == b_delay);
      out_bresp  = (d == b_delay) ? b_resp_val : 2'b00;
      #1;
      chk("b_fwd", {lsu_bvalid, lsu_bresp, out_bready}, {out_bvalid, out_bresp, 1'b1});
      chk("b_ifu_blocked", {ifu_arready, out_arvalid}, 0);
      step();
    end
    slave_quiet(); master_quiet();
  endtask

  // Serve every pending request in the order the reference rule predicts.
  task automatic run(input int ar_stall, input int b_delay, input int rst_beat, input int n_reissue);
    int kind;
    int n = 0;
    kind = pick(ifu_arvalid, lsu_arvalid, lsu_awvalid);
    while (kind != 0 && n < 12) begin
      out_rvalid = 1; out_rdata = 32'hA5A5_0001; out_rlast = 1; out_rresp = 2'b11;
      out_arready = 1; out_awready = 1; out_wready = 1; out_bvalid = 1; out_bresp = 2'b10;
      ifu_rready = 1; lsu_rready = 1; lsu_bready = 1; lsu_wvalid = 1; lsu_wlast = 1;
      lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
      #1;
      check_idle("arb_cycle");
      step();
      glog.push_back(kind);
      mdl_last_lsu = (kind != 1);
      if (kind == 3) serve_wr(ar_stall, b_delay);
      else serve_rd(kind == 1, ar_stall, rst_beat, n < n_reissue);
      rst_beat = -1;
      n++;
      kind = pick(ifu_arvalid, lsu_arvalid, lsu_awvalid);
    end
    #1;
    check_idle("drained");
  endtask

  initial begin
    int exp_seq[4];
    ifu_araddr = 0; ifu_arlen = 0; ifu_arburst = AXI_BURST_INCR; ifu_arvalid = 0;
    lsu_araddr = 0; lsu_arlen = 0; lsu_arburst = AXI_BURST_INCR; lsu_arvalid = 0;
    lsu_awaddr = 0; lsu_awlen = 0; lsu_awvalid = 0;
    slave_quiet(); master_quiet();
    do_reset();

    // IFU alone, 4-beat burst from 0x8000_0000
    ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd3; ifu_arvalid = 1;
    run(0, 0, -1, 0);

    // IFU and LSU read in the same cycle
    glog.delete();
    ifu_araddr = 32'h8000_0040; ifu_arlen = 8'd1; ifu_arvalid = 1;
    lsu_araddr = 32'h9000_0100; lsu_arlen = 8'd0; lsu_arvalid = 1;
    run(1, 0, -1, 0);
    chk("both_first_lsu", glog[0], 2);
    chk("both_then_ifu", glog[1], 1);

    // Both masters keep requesting: grant order reveals the priority scheme
    do_reset();
    glog.delete();
    ifu_araddr = 32'h8000_1000; ifu_arlen = 8'd0; ifu_arvalid = 1;
    lsu_araddr = 32'h9000_2000; lsu_arlen = 8'd1; lsu_arvalid = 1;
    run(0, 0, -1, 3);
`ifdef MEM_BUS_ARB_RR_EN
    exp_seq = '{2, 1, 2, 1};
`else
    exp_seq = '{2, 2, 2, 2};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("grant_seq%0d", i), glog[i], exp_seq[i]);

    // LSU write with slow B while IFU waits
    do_reset();
    glog.delete();
    wr_use_first = 1; wr_first_data = 32'hDEAD_BEEF; b_resp_val = AXI_RESP_OKAY;
    lsu_awaddr = 32'h8000_0010; lsu_awlen = 8'd0; lsu_awvalid = 1;
    ifu_araddr = 32'h8000_0200; ifu_arlen = 8'd0; ifu_arvalid = 1;
    run(0, 5, -1, 0);
    chk("wr_first", glog[0], 3);
    chk("ifu_after_wr", glog[1], 1);
    wr_use_first = 0;

    // AR stalled 3 cycles by the slave
    ifu_araddr = 32'h8000_0300; ifu_arlen = 8'd2; ifu_arvalid = 1;
    run(3, 0, -1, 0);

    // Reset after beat 2 of 4, then a normal IFU request
    ifu_araddr = 32'h8000_0400; ifu_arlen = 8'd3; ifu_arvalid = 1;
    run(0, 0, 2, 0);
    glog.delete();
    ifu_araddr = 32'h8000_0500; ifu_arlen = 8'd3; ifu_arvalid = 1;
    run(0, 0, -1, 0);
    chk("post_rst_grant", glog.size(), 1);

    // Randomised mixes of concurrent requests
    for (int it = 0; it < 20; it++) begin
      ifu_arvalid = 1'($urandom); lsu_arvalid = 1'($urandom); lsu_awvalid = 1'($urandom);
      if (!ifu_arvalid && !lsu_arvalid && !lsu_awvalid) ifu_arvalid = 1;
      ifu_araddr = 32'h8000_0000 | ($urandom & 32'h00FF_FFC0); ifu_arlen = 8'($urandom_range(0, 3));
      lsu_araddr = 32'h9000_0000 | ($urandom & 32'h00FF_FFC0); lsu_arlen = 8'($urandom_range(0, 3));
      lsu_awaddr = 32'hA000_0000 | ($urandom & 32'h00FF_FFC0); lsu_awlen = 8'($urandom_range(0, 3));
      b_resp_val = 2'($urandom);
      run($urandom_range(0, 2), $urandom_range(0, 3), -1, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
